// File: rtl/conv_pkg.sv
// Shared definitions for the 802.11a K=7 convolutional encoder and puncturer:
// rate codes, default generators, FSM states and puncture patterns.
package conv_pkg;

  localparam logic [1:0] RATE_1_2 = 2'd0;
  localparam logic [1:0] RATE_2_3 = 2'd1;
  localparam logic [1:0] RATE_3_4 = 2'd2;

  // Tap vectors: bit 6 is the current input, bit 0 the oldest register stage.
  localparam logic [6:0] G0_DEFAULT = 7'b1011011;
  localparam logic [6:0] G1_DEFAULT = 7'b1111001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Keep masks packed by phase, two bits per phase: bit0 keeps A, bit1 keeps B.
  localparam logic [3:0] KEEP_2_3 = {2'b01, 2'b11};
  localparam logic [5:0] KEEP_3_4 = {2'b10, 2'b01, 2'b11};

  function automatic logic [1:0] punct_period(input logic [1:0] rate);
    case (rate)
      RATE_2_3: punct_period = 2'd2;
      RATE_3_4: punct_period = 2'd3;
      default:  punct_period = 2'd1;
    endcase
  endfunction

  function automatic logic [1:0] keep_mask(input logic [1:0] rate, input logic [1:0] phase);
    case (rate)
      RATE_2_3: keep_mask = KEEP_2_3[{phase[0], 1'b0} +: 2];
      RATE_3_4: keep_mask = (phase == 2'd3) ? 2'b11 : KEEP_3_4[{phase, 1'b0} +: 2];
      default:  keep_mask = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/conv_core.sv
// Six-stage encoder shift register with the two generator parity trees;
// outputs reflect the window formed by the current in_bit and past bits.
module conv_core
  import conv_pkg::*;
#(
  parameter logic [6:0] G0 = G0_DEFAULT,
  parameter logic [6:0] G1 = G1_DEFAULT
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clear,
  input  logic shift,
  input  logic in_bit,
  output logic a,
  output logic b
);

  logic [5:0] sr_q, sr_d;
  logic [6:0] window;

  always_comb begin
    sr_d = sr_q;
    if (clear) begin
      sr_d = '0;
    end else if (shift) begin
      sr_d = {in_bit, sr_q[5:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign window = {in_bit, sr_q};
  assign a      = ^(window & G0);
  assign b      = ^(window & G1);

endmodule

// File: rtl/conv_encoder_puncturer.sv
// Rate-1/2 K=7 encoder with 2/3 and 3/4 puncturing, repacking the variable
// number of coded bits per input into 2-bit output pairs via a 4-bit FIFO.
module conv_encoder_puncturer
  import conv_pkg::*;
#(
  parameter logic [6:0] G0 = G0_DEFAULT,
  parameter logic [6:0] G1 = G1_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       start,
  input  logic [1:0] rate,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [1:0] rate_q, rate_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] buf_q, buf_d;
  logic [2:0] count_q, count_d;

  logic       start_ok, accept, pop, code_a, code_b;
  logic [1:0] keep, push_bits;
  logic [2:0] popped, pushed, base;
  logic [3:0] shifted;

  assign start_ok  = (state_q == IDLE) & start;
  assign out_valid = (count_q >= 3'd2) | ((state_q == DRAIN) & (count_q == 3'd1));
  assign out_last  = out_valid & (state_q == DRAIN) & (count_q <= 3'd2);
  assign out_data  = !out_valid ? 2'b00 :
                     (count_q == 3'd1) ? {1'b0, buf_q[0]} : buf_q[1:0];
  assign busy      = (state_q != IDLE);

  // in_ready looks through this cycle's pop so the FIFO can stream at full rate.
  assign pop      = out_valid & out_ready;
  assign popped   = !pop ? 3'd0 : ((count_q == 3'd1) ? 3'd1 : 3'd2);
  assign base     = count_q - popped;
  assign in_ready = (state_q == RUN) & (base <= 3'd2);
  assign accept   = in_valid & in_ready;

  conv_core #(
    .G0(G0),
    .G1(G1)
  ) u_core (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clear (start_ok),
    .shift (accept),
    .in_bit(in_bit),
    .a     (code_a),
    .b     (code_b)
  );

  assign keep      = keep_mask(rate_q, phase_q);
  assign push_bits = (keep == 2'b11) ? {code_b, code_a} :
                     (keep == 2'b01) ? {1'b0, code_a} : {1'b0, code_b};
  assign pushed    = !accept ? 3'd0 : ((keep == 2'b11) ? 3'd2 : 3'd1);
  assign shifted   = buf_q >> popped;

  // New bits land just above the survivors of this cycle's pop.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_buf
      localparam logic [2:0] POS = 3'(gi);
      assign buf_d[gi] = ((pushed != 3'd0) && (base == POS)) ? push_bits[0] :
                         ((pushed == 3'd2) && (base + 3'd1 == POS)) ? push_bits[1] :
                         shifted[gi];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    phase_d = phase_q;
    count_d = count_q - popped + pushed;
    if (start_ok) begin
      rate_d  = rate;
      phase_d = 2'd0;
    end else if (accept) begin
      phase_d = (phase_q + 2'd1 == punct_period(rate_q)) ? 2'd0 : phase_q + 2'd1;
    end
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept & in_last) state_d = DRAIN;
      DRAIN:   if (count_d == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      rate_q  <= RATE_1_2;
      phase_q <= 2'd0;
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      phase_q <= phase_d;
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

endmodule
